// File: rtl/sram_rmw_master.sv
// CPU-side SRAM-like request initiator for a single-port asynchronous word RAM.
// Sub-word stores are done as read-modify-write because the RAM only has a word write enable.
module sram_rmw_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wr,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_spo
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRD  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic                    wr_q;
  logic [3:0]              wstrb_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   merge_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    accept_s;
  logic                    unused_addr_s;

  // Byte-lane merge: strobed lanes come from the new data, the rest from the RAM word.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [3:0]            strb,
    input logic [DATA_WIDTH-1:0] new_d,
    input logic [DATA_WIDTH-1:0] old_d
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_d;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_d[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_d[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign addr_ok       = ((state == IDLE) || (state == DONE)) && !reset;
  assign accept_s      = addr_ok && req;
  assign data_ok       = (state == DONE);
  assign rdata         = rdata_q;
  assign ram_a         = a_q;
  assign ram_d         = merge_q;
  assign ram_we        = (state == WR) && (wstrb_q != 4'h0);
  assign unused_addr_s = ^{addr[31:ADDR_WIDTH+2], addr[1:0], wr_q};

  // Transaction sequencer and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'h0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept_s) begin
            a_q     <= addr[ADDR_WIDTH+1:2];
            wr_q    <= wr;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            if (!wr) begin
              state <= RD;
            end else if (wstrb == 4'hF) begin
              merge_q <= wdata;
              state   <= WR;
            end else begin
              state <= MRD;
            end
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          rdata_q <= ram_spo;
          state   <= DONE;
        end
        MRD: begin
          merge_q <= merge_bytes(wstrb_q, wdata_q, ram_spo);
          state   <= WR;
        end
        WR: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rmw_master.sv
// Directed bench for sram_rmw_master with a behavioural RAM, a reference memory
// and a transaction scoreboard checked at each data_ok.
module tb_sram_rmw_master;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          wr;
  logic [3:0]    wstrb;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [31:0]   rdata;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_d;
  logic [31:0]   ram_spo;

  logic [31:0]   mem     [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [31:0]   pre_d  = 32'd0;

  typedef struct {
    logic          w;
    logic [AW-1:0] idx;
    logic [3:0]    s;
    logic [31:0]   d;
  } txn_t;
  txn_t sb[$];

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int we0;

  always #5 clk = ~clk;

  sram_rmw_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
  );

  // Asynchronous-read, clocked-write RAM with a bench-side preload port.
  assign ram_spo = mem[ram_a];
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_a] <= ram_d;
    else if (pre_en) mem[pre_a] <= pre_d;
  end

  always @(negedge clk) begin
    if (ram_we === 1'b1) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req   = 1'b0;
    wr    = 1'($urandom);
    wstrb = 4'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pre_en = 1'b1;
    pre_a  = AW'(idx);
    pre_d  = val;
    ref_mem[idx] = val;
    step();
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    txn_t t;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = d;
    chk("addr_ok", {31'd0, addr_ok}, 32'd1);
    t.w   = w;
    t.idx = a[AW+1:2];
    t.s   = s;
    t.d   = d;
    sb.push_back(t);
  endtask

  task automatic done_chk(input string tag);
    txn_t t;
    logic [31:0] m;
    chk({tag, "_data_ok"}, {31'd0, data_ok}, 32'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      t = sb.pop_front();
      if (!t.w) begin
        chk({tag, "_rdata"}, rdata, ref_mem[t.idx]);
      end else begin
        m = ref_mem[t.idx];
        for (int i = 0; i < 4; i++) if (t.s[i]) m[8*i +: 8] = t.d[8*i +: 8];
        ref_mem[t.idx] = m;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    chk("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_a", {17'd0, ram_a}, 32'd0);
    chk("rst_ram_d", ram_d, 32'd0);
    preload(5, 32'h1122_3344);
    preload(8, 32'h0000_0000);
    preload(3, 32'hAABB_CCDD);
    preload(7, 32'h0101_0101);
    preload(9, 32'h9988_7766);
    reset = 1'b0;
    step();

    // Plain read: data_ok two cycles after accept, no write strobe.
    we0 = we_cnt;
    drive(1'b0, 32'h0000_0014, 4'h0, 32'd0);
    step(); clear_inputs();
    chk("rd_n1_data_ok", {31'd0, data_ok}, 32'd0);
    step();
    done_chk("rd");
    chk("rd_rdata_const", rdata, 32'h1122_3344);
    step();
    chk("rd_no_we", we_cnt, we0);

    // Full-word write: single WR cycle then DONE.
    drive(1'b1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF);
    step(); clear_inputs();
    chk("fw_we", {31'd0, ram_we}, 32'd1);
    chk("fw_a", {17'd0, ram_a}, 32'd8);
    chk("fw_d", ram_d, 32'hDEAD_BEEF);
    step();
    chk("fw_we_off", {31'd0, ram_we}, 32'd0);
    done_chk("fw");
    step();

    // Back-to-back: read, full write, read to the same word, chained from DONE.
    drive(1'b0, 32'h0000_0020, 4'h0, 32'd0);
    step(); clear_inputs();
    chk("b2b_n1_data_ok", {31'd0, data_ok}, 32'd0);
    step();
    done_chk("b2b_rd1");
    chk("b2b_rd1_const", rdata, 32'hDEAD_BEEF);
    drive(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678);
    step(); clear_inputs();
    chk("b2b_wr_we", {31'd0, ram_we}, 32'd1);
    chk("b2b_wr_no_done", {31'd0, data_ok}, 32'd0);
    step();
    done_chk("b2b_wr");
    drive(1'b0, 32'h0000_0020, 4'h0, 32'd0);
    step(); clear_inputs();
    step();
    done_chk("b2b_rd2");
    chk("b2b_rd2_const", rdata, 32'h1234_5678);
    step();

    // Partial write: MRD then WR with merged word.
    drive(1'b1, 32'h0000_000C, 4'b0010, 32'h0000_5500);
    step(); clear_inputs();
    chk("pw_mrd_we", {31'd0, ram_we}, 32'd0);
    chk("pw_mrd_done", {31'd0, data_ok}, 32'd0);
    step();
    chk("pw_wr_we", {31'd0, ram_we}, 32'd1);
    chk("pw_wr_d", ram_d, 32'hAABB_55DD);
    chk("pw_wr_done", {31'd0, data_ok}, 32'd0);
    step();
    chk("pw_we_off", {31'd0, ram_we}, 32'd0);
    done_chk("pw");
    step();

    // Reset asserted during MRD discards the write.
    drive(1'b1, 32'h0000_000C, 4'b1000, 32'h7700_0000);
    step(); clear_inputs();
    #1 reset = 1'b1;
    #1;
    chk("mr_addr_ok", {31'd0, addr_ok}, 32'd0);
    chk("mr_data_ok", {31'd0, data_ok}, 32'd0);
    chk("mr_ram_we", {31'd0, ram_we}, 32'd0);
    chk("mr_rdata", rdata, 32'd0);
    chk("mr_ram_a", {17'd0, ram_a}, 32'd0);
    chk("mr_ram_d", ram_d, 32'd0);
    sb.delete();
    step();
    chk("mr_hold_we", {31'd0, ram_we}, 32'd0);
    chk("mr_hold_data_ok", {31'd0, data_ok}, 32'd0);
    reset = 1'b0;
    step();
    chk("mr_mem3", mem[3], 32'hAABB_55DD);
    drive(1'b0, 32'h0000_000C, 4'h0, 32'd0);
    step(); clear_inputs();
    step();
    done_chk("mr_rd");
    step();

    // Alias: high address bit above the word index is ignored.
    drive(1'b1, 32'h0002_001C, 4'hF, 32'hCAFE_F00D);
    step(); clear_inputs();
    chk("al_a", {17'd0, ram_a}, 32'd7);
    step();
    done_chk("al_wr");
    step();
    drive(1'b0, 32'h0000_001C, 4'h0, 32'd0);
    step(); clear_inputs();
    step();
    done_chk("al_rd");
    chk("al_rd_const", rdata, 32'hCAFE_F00D);
    step();

    // Zero strobe: full RMW timing but never a write pulse.
    we0 = we_cnt;
    drive(1'b1, 32'h0000_0024, 4'h0, 32'hFFFF_FFFF);
    step(); clear_inputs();
    chk("zs_n1_done", {31'd0, data_ok}, 32'd0);
    step();
    chk("zs_n2_we", {31'd0, ram_we}, 32'd0);
    chk("zs_n2_done", {31'd0, data_ok}, 32'd0);
    step();
    done_chk("zs");
    step();
    chk("zs_no_we", we_cnt, we0);
    drive(1'b0, 32'h0000_0024, 4'h0, 32'd0);
    step(); clear_inputs();
    step();
    done_chk("zs_rd");
    chk("zs_rd_const", rdata, 32'h9988_7766);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
